xor_share_arbiter: RTL and testbench

Shares one 4-bit bitwise XOR/XNOR datapath between two requesters.
- Round-robin arbitration between the requesters.
- Valid/ready handshakes on both request ports and on the single response port.
- Registered result; accepts one operation per cycle when the response side does not stall.
- Sits between operand producers (test sequencers, ALU front-ends) and any consumer of XOR/XNOR results.

---
 rtl/xor_share_arbiter_pkg.sv | 14 +
 rtl/xor_share_arbiter_if.sv | 50 +++++
 rtl/xor_share_arbiter_op_unit.sv | 13 +
 rtl/xor_share_arbiter.sv | 104 ++++++++++
 tb/tb_xor_share_arbiter.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/xor_share_arbiter_pkg.sv
// Shared types and constants for the two-requester XOR/XNOR arbiter.
// XOR_SHARE_STATS_EN (optional) adds per-requester grant counters.
package xor_share_pkg;

    localparam int XS_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef logic rr_idx_t;

endpackage

// File: rtl/xor_share_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and one consumer.
// XOR_SHARE_STATS_EN adds the grant counters to the bundle.
interface xor_share_if #(
    parameter int WIDTH = 4
);
    // Transfer happens on a cycle where valid && ready; valid and payload hold until then.
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_inv;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_inv;
    logic             req1_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_ready;
`ifdef XOR_SHARE_STATS_EN
    logic [15:0]      grant_cnt0;
    logic [15:0]      grant_cnt1;
`endif

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_inv,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_inv,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready
`ifdef XOR_SHARE_STATS_EN
        , output grant_cnt0, grant_cnt1
`endif
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_inv,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_inv,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready
`ifdef XOR_SHARE_STATS_EN
        , input grant_cnt0, grant_cnt1
`endif
    );

endinterface

// File: rtl/xor_share_arbiter_op_unit.sv
// Combinational XOR / XNOR datapath shared by both requesters.
module xor_op_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             inv_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = inv_i ? ~(a_i ^ b_i) : (a_i ^ b_i);

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one registered XOR/XNOR unit between two requesters.
// XOR_SHARE_STATS_EN adds 16-bit wrapping grant counters per requester.
module xor_share_arbiter
    import xor_share_pkg::*;
#(
    parameter int WIDTH   = XS_WIDTH,
    parameter bit RR_INIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    xor_share_if.slave   bus,
    output state_t       state_o
);

    state_t           state_q, state_d;
    rr_idx_t          last_grant_q, last_grant_d;
    rr_idx_t          rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             can_accept;
    logic             gnt_valid;
    rr_idx_t          gnt_id;
    logic             hs;
    logic [WIDTH-1:0] op_a, op_b, op_y;
    logic             op_inv;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_valid  = bus.req0_valid | bus.req1_valid;
        gnt_id     = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_id = ~last_grant_q;
        end
        can_accept = (state_q == IDLE) || bus.rsp_ready;
        hs         = !rst && can_accept && gnt_valid;
    end

    assign op_a   = gnt_id ? bus.req1_a   : bus.req0_a;
    assign op_b   = gnt_id ? bus.req1_b   : bus.req0_b;
    assign op_inv = gnt_id ? bus.req1_inv : bus.req0_inv;

    xor_op_unit #(.WIDTH(WIDTH)) u_op (
        .a_i   (op_a),
        .b_i   (op_b),
        .inv_i (op_inv),
        .y_o   (op_y)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: if (hs) state_d = RESP;
            RESP: if (bus.rsp_ready && !hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (hs) begin
            rsp_data_d   = op_y;
            rsp_id_d     = gnt_id;
            last_grant_d = gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= RR_INIT;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign bus.req0_ready = hs && (gnt_id == 1'b0);
    assign bus.req1_ready = hs && (gnt_id == 1'b1);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign state_o        = state_q;

`ifdef XOR_SHARE_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (hs) begin
            if (gnt_id == 1'b0) cnt0_q <= cnt0_q + 16'd1;
            else                cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Self-checking bench for xor_share_arbiter: directed plan steps then random traffic
// against a cycle-level reference model and an in-order result scoreboard.
module tb_xor_share_arbiter;
  import xor_share_pkg::*;

  localparam int W  = 4;
  localparam bit RR = 1'b1;

  logic   clk = 1'b0;
  logic   rst;
  state_t state;

  always #5 clk = ~clk;

  xor_share_if #(.WIDTH(W)) bus ();

  xor_share_arbiter #(.WIDTH(W), .RR_INIT(RR)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the consumer should see, in terms of results held.
  bit          m_valid;
  logic [W-1:0] m_data;
  bit          m_id;
  bit          m_last;
  logic [15:0] m_cnt0, m_cnt1;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inv);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = (a[k] != b[k]) ? ~inv : inv;
    return r;
  endfunction

  task automatic step(input bit r, input bit rr,
                      input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input bit i0,
                      input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input bit i1);
    bit free, win, hs;
    @(negedge clk);
    rst = r;
    bus.rsp_ready  = rr;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_inv = i0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_inv = i1;
    #1;
    free = !m_valid || rr;
    win  = (v0 && v1) ? !m_last : v1;
    hs   = !r && free && (v0 || v1);
    chk("req0_ready", 32'(bus.req0_ready), 32'(hs && !win));
    chk("req1_ready", 32'(bus.req1_ready), 32'(hs && win));
    chk("rsp_valid",  32'(bus.rsp_valid),  32'(m_valid));
    chk("rsp_data",   32'(bus.rsp_data),   32'(m_data));
    chk("rsp_id",     32'(bus.rsp_id),     32'(m_id));
    chk("state",      32'(state),          32'(m_valid ? RESP : IDLE));
`ifdef XOR_SHARE_STATS_EN
    chk("grant_cnt0", 32'(bus.grant_cnt0), 32'(m_cnt0));
    chk("grant_cnt1", 32'(bus.grant_cnt1), 32'(m_cnt1));
`endif
    if (!r && bus.rsp_valid && rr) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      else                   chk("sb_result", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = '0; m_id = 0; m_last = RR;
      m_cnt0 = '0; m_cnt1 = '0;
      exp_q.delete();
    end else if (hs) begin
      m_valid = 1;
      m_id    = win;
      m_last  = win;
      m_data  = win ? ref_op(a1, b1, i1) : ref_op(a0, b0, i0);
      exp_q.push_back(m_data);
      if (win) m_cnt1 = m_cnt1 + 16'd1;
      else     m_cnt0 = m_cnt0 + 16'd1;
    end else if (rr) begin
      m_valid = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_inv = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_inv = 1'b0;
    m_valid = 0; m_data = '0; m_id = 0; m_last = RR; m_cnt0 = '0; m_cnt1 = '0;

    // Reset with both requesters asserting valid.
    step(1, 1, 1, 4'h1, 4'h2, 0, 1, 4'h3, 4'h4, 0);
    step(1, 1, 1, 4'h1, 4'h2, 0, 1, 4'h3, 4'h4, 0);
    // First tie after reset goes to requester 0.
    step(0, 1, 1, 4'h1, 4'h2, 0, 1, 4'h3, 4'h4, 0);
    #1 chk("t1_first_id", 32'(bus.rsp_id), 32'd0);

    step(0, 1, 1, 4'b0101, 4'b0110, 0, 0, 4'h0, 4'h0, 0);
    #1 chk("t2_xor", 32'(bus.rsp_data), 32'(4'b0011));
    chk("t2_id", 32'(bus.rsp_id), 32'd0);

    step(0, 1, 0, 4'h0, 4'h0, 0, 1, 4'b0101, 4'b0110, 1);
    #1 chk("t3_xnor", 32'(bus.rsp_data), 32'(4'b1100));
    chk("t3_id", 32'(bus.rsp_id), 32'd1);

    // Continuous contention: grants alternate, one result per cycle.
    for (int i = 0; i < 6; i++) step(0, 1, 1, 4'b1111, 4'b0000, 0, 1, 4'b1010, 4'b1010, 0);

    // Backpressure for three cycles, then release.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 4'b1111, 4'b0000, 0, 1, 4'b1010, 4'b1010, 0);
    step(0, 1, 1, 4'b1111, 4'b0000, 0, 1, 4'b1010, 4'b1010, 0);
    #1 chk("t5_release_id", 32'(bus.rsp_id), 32'd0);

    // Reset while a result is held under backpressure.
    step(0, 0, 1, 4'h9, 4'h3, 0, 1, 4'h6, 4'h1, 1);
    step(1, 0, 1, 4'h9, 4'h3, 0, 1, 4'h6, 4'h1, 1);
    step(0, 1, 1, 4'h9, 4'h3, 0, 1, 4'h6, 4'h1, 1);
    #1 chk("t6_after_rst_id", 32'(bus.rsp_id), 32'd0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    // Starvation bound: req0 held high is granted within two accepted ops.
    step(0, 1, 0, 4'h0, 4'h0, 0, 1, 4'h5, 4'h5, 0);
    step(0, 1, 1, 4'hA, 4'h5, 0, 1, 4'h5, 4'h5, 0);
    #1 chk("starve_id", 32'(bus.rsp_id), 32'd0);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
